// File: rtl/product_reduce.sv
// rtl/product_reduce.sv - signed sum reduction of N words read from a product BRAM
//
// Purpose: on a rising edge of the start bit, read N consecutive words from the
// product BRAM (1-cycle read latency), sign-extend and accumulate them, then
// report the sum and status until acknowledged.
//
// Ports:
//   clk                  sole clock, all state on posedge
//   reset                asynchronous active-low reset
//   ps_control[31:0]     bit0 start, bit1 ack, [31:16] word count N
//   pl_status[31:0]      bit0 done, bit1 busy, bit2 overflow, rest 0
//   bram_addr_product    product BRAM byte address
//   bram_rddata_product  product BRAM read data
//   bram_wrdata_product  tied 0
//   bram_we_product      tied 0 (read-only consumer)
//   sum_out              signed reduction result

module product_reduce #(
   parameter int BRAM_WIDTH = 32,
   parameter int WORD_BYTES = 4,
   parameter int ADDR_WIDTH = 12,
   parameter int NUM_WORDS  = 1024,
   parameter int ACC_WIDTH  = 48
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           ps_control,
   output logic [31:0]           pl_status,
   output logic [ADDR_WIDTH-1:0] bram_addr_product,
   input  logic [BRAM_WIDTH-1:0] bram_rddata_product,
   output logic [BRAM_WIDTH-1:0] bram_wrdata_product,
   output logic [WORD_BYTES-1:0] bram_we_product,
   output logic [ACC_WIDTH-1:0]  sum_out
);

   localparam int CW = $clog2(NUM_WORDS + 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t               state_q, state_d;
   logic                 start_prev_q;
   logic                 armed_q;
   logic                 vld_q, vld_d;
   logic                 ovf_q, ovf_d;
   logic [CW-1:0]        n_q, n_d;
   logic [CW-1:0]        idx_q, idx_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;

   logic                 start_edge;
   logic                 ack;
   logic [CW-1:0]        n_clamped;
   logic [ACC_WIDTH-1:0] word_ext;
   logic [ACC_WIDTH-1:0] add_sum;
   logic                 add_ovf;
   logic                 unused_ctrl;

   // The previous-start register is cleared by reset, so a level held high
   // through reset release would look like an edge; armed_q masks the first
   // cycle after release so only a fresh 0->1 transition launches a run.
   assign start_edge = armed_q & ps_control[0] & ~start_prev_q;
   assign ack        = ps_control[1];

   assign n_clamped = (32'(ps_control[31:16]) > 32'(NUM_WORDS)) ? CW'(NUM_WORDS)
                                                                : CW'(ps_control[31:16]);

   assign word_ext = {{(ACC_WIDTH-BRAM_WIDTH){bram_rddata_product[BRAM_WIDTH-1]}},
                      bram_rddata_product};
   assign add_sum  = acc_q + word_ext;
   // Signed overflow: operands share a sign and the result's sign differs.
   assign add_ovf  = (acc_q[ACC_WIDTH-1] == word_ext[ACC_WIDTH-1]) &&
                     (add_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      vld_d   = 1'b0;

      // Data for the address issued last cycle is on the read port now.
      if (vld_q) begin
         acc_d = add_sum;
         if (add_ovf) begin
            ovf_d = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (start_edge) begin
               n_d     = n_clamped;
               idx_d   = '0;
               acc_d   = '0;
               ovf_d   = 1'b0;
               state_d = (n_clamped == '0) ? DONE : READ;
            end
         end
         READ: begin
            vld_d = 1'b1;
            idx_d = idx_q + CW'(1);
            if (idx_q == n_q - CW'(1)) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            state_d = DONE;
         end
         DONE: begin
            // Ack wins over a coincident start edge; that edge is consumed.
            if (ack) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         start_prev_q <= 1'b0;
         armed_q      <= 1'b0;
         vld_q        <= 1'b0;
         ovf_q        <= 1'b0;
         n_q          <= '0;
         idx_q        <= '0;
         acc_q        <= '0;
      end else begin
         state_q      <= state_d;
         start_prev_q <= ps_control[0];
         armed_q      <= 1'b1;
         vld_q        <= vld_d;
         ovf_q        <= ovf_d;
         n_q          <= n_d;
         idx_q        <= idx_d;
         acc_q        <= acc_d;
      end
   end

   assign bram_addr_product   = (state_q == READ) ?
                                ADDR_WIDTH'(idx_q) * ADDR_WIDTH'(WORD_BYTES) : '0;
   assign pl_status           = {29'b0, ovf_q,
                                 (state_q == READ) || (state_q == DRAIN),
                                 (state_q == DONE)};
   assign sum_out             = acc_q;
   assign bram_wrdata_product = '0;
   assign bram_we_product     = '0;

   assign unused_ctrl = ^ps_control[15:2];

endmodule

// File: tb/tb_product_reduce.sv
// tb/tb_product_reduce.sv - directed self-checking bench for product_reduce

module tb_product_reduce;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [31:0] ps_control, pl_status;
   logic [11:0] addr;
   logic [31:0] rdata, wrdata;
   logic [3:0]  we;
   logic [47:0] sum_out;

   logic [31:0] ps_control2, pl_status2;
   logic [11:0] addr2;
   logic [31:0] rdata2, wrdata2;
   logic [3:0]  we2;
   logic [32:0] sum2;

   logic [31:0] mem [0:1023];
   int          n_checks = 0;
   int          n_pass = 0;
   logic        side_bad = 1'b0;

   product_reduce dut (
      .clk(clk), .reset(reset), .ps_control(ps_control), .pl_status(pl_status),
      .bram_addr_product(addr), .bram_rddata_product(rdata),
      .bram_wrdata_product(wrdata), .bram_we_product(we), .sum_out(sum_out));

   product_reduce #(.ACC_WIDTH(33)) dut33 (
      .clk(clk), .reset(reset), .ps_control(ps_control2), .pl_status(pl_status2),
      .bram_addr_product(addr2), .bram_rddata_product(rdata2),
      .bram_wrdata_product(wrdata2), .bram_we_product(we2), .sum_out(sum2));

   // One-cycle-latency BRAM model
   always @(posedge clk) rdata <= mem[addr[11:2]];
   assign rdata2 = 32'h7FFF_FFFF;

   always @(negedge clk)
      if (we !== 4'h0 || wrdata !== 32'h0 || we2 !== 4'h0 || wrdata2 !== 32'h0)
         side_bad = 1'b1;

   task automatic fill(input logic [31:0] v, input bit ramp);
      for (int i = 0; i < 1024; i++) mem[i] = ramp ? 32'(i) : v;
   endtask

   // Launch a run and wait for done; cyc = posedges after the start edge until done seen.
   task automatic do_run(input int n, input bit keep, output int cyc, output logic [47:0] sum,
                         output logic [31:0] st, output int busy_err, output int max_addr);
      @(negedge clk);
      ps_control = {n[15:0], 16'h0001};
      cyc = 0; busy_err = 0; max_addr = 0;
      @(negedge clk);
      while (pl_status[0] !== 1'b1 && cyc < 3000) begin
         if (pl_status[1] !== 1'b1) busy_err++;
         if (int'(addr) > max_addr) max_addr = int'(addr);
         @(negedge clk);
         cyc++;
      end
      sum = sum_out;
      st  = pl_status;
      if (!keep) ps_control[0] = 1'b0;
   endtask

   task automatic do_ack();
      @(negedge clk); ps_control[1] = 1'b1;
      @(negedge clk); ps_control[1] = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; ps_control = '0; ps_control2 = '0;
      fill(32'h0, 1'b0);
      repeat (2) @(negedge clk);
      n_checks++; if (pl_status !== 32'h0) $display("FAIL reset_status: got %h expected %h", pl_status, 32'h0); else n_pass++;
      n_checks++; if (sum_out !== 48'h0) $display("FAIL reset_sum: got %h expected %h", sum_out, 48'h0); else n_pass++;
      n_checks++; if (addr !== 12'h0) $display("FAIL reset_addr: got %h expected %h", addr, 12'h0); else n_pass++;
      n_checks++; if (pl_status2 !== 32'h0) $display("FAIL reset_status33: got %h expected %h", pl_status2, 32'h0); else n_pass++;
      @(negedge clk); reset = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_all_sixes();
      int cyc, be, ma; logic [47:0] s; logic [31:0] st;
      fill(32'd6, 1'b0);
      do_run(1024, 1'b0, cyc, s, st, be, ma);
      n_checks++; if (cyc !== 1025) $display("FAIL sixes_latency: got %0d expected %0d", cyc, 1025); else n_pass++;
      n_checks++; if (s !== 48'd6144) $display("FAIL sixes_sum: got %0d expected %0d", s, 6144); else n_pass++;
      n_checks++; if (st !== 32'h1) $display("FAIL sixes_status: got %h expected %h", st, 32'h1); else n_pass++;
      n_checks++; if (be !== 0) $display("FAIL sixes_busy: got %0d non-busy cycles expected 0", be); else n_pass++;
      n_checks++; if (ma !== 4092) $display("FAIL sixes_maxaddr: got %0d expected %0d", ma, 4092); else n_pass++;
      n_checks++; if (addr !== 12'h0) $display("FAIL sixes_done_addr: got %h expected %h", addr, 12'h0); else n_pass++;
      do_ack();
      n_checks++; if (pl_status !== 32'h0) $display("FAIL sixes_ack_status: got %h expected %h", pl_status, 32'h0); else n_pass++;
      n_checks++; if (sum_out !== 48'd6144) $display("FAIL sixes_ack_sum: got %0d expected %0d", sum_out, 6144); else n_pass++;
   endtask

   task automatic test_negative();
      int cyc, be, ma; logic [47:0] s; logic [31:0] st;
      fill(32'hFFFF_FFFF, 1'b0);
      do_run(16, 1'b0, cyc, s, st, be, ma);
      n_checks++; if (cyc !== 17) $display("FAIL neg_latency: got %0d expected %0d", cyc, 17); else n_pass++;
      n_checks++; if (s !== 48'hFFFF_FFFF_FFF0) $display("FAIL neg_sum: got %h expected %h", s, 48'hFFFF_FFFF_FFF0); else n_pass++;
      n_checks++; if (st !== 32'h1) $display("FAIL neg_status: got %h expected %h", st, 32'h1); else n_pass++;
      do_ack();
   endtask

   task automatic test_ramp();
      int cyc, be, ma; logic [47:0] s; logic [31:0] st;
      fill(32'h0, 1'b1);
      do_run(8, 1'b0, cyc, s, st, be, ma);
      n_checks++; if (s !== 48'd28) $display("FAIL ramp_sum: got %0d expected %0d", s, 28); else n_pass++;
      n_checks++; if (cyc !== 9) $display("FAIL ramp_latency: got %0d expected %0d", cyc, 9); else n_pass++;
      n_checks++; if (ma !== 28) $display("FAIL ramp_maxaddr: got %0d expected %0d", ma, 28); else n_pass++;
      do_ack();
   endtask

   task automatic test_clamp();
      int cyc, be, ma; logic [47:0] s; logic [31:0] st;
      fill(32'd6, 1'b0);
      do_run(2000, 1'b0, cyc, s, st, be, ma);
      n_checks++; if (cyc !== 1025) $display("FAIL clamp_latency: got %0d expected %0d", cyc, 1025); else n_pass++;
      n_checks++; if (s !== 48'd6144) $display("FAIL clamp_sum: got %0d expected %0d", s, 6144); else n_pass++;
      n_checks++; if (ma !== 4092) $display("FAIL clamp_maxaddr: got %0d expected %0d", ma, 4092); else n_pass++;
      do_ack();
   endtask

   task automatic test_zero();
      int cyc, be, ma; logic [47:0] s; logic [31:0] st;
      do_run(0, 1'b0, cyc, s, st, be, ma);
      n_checks++; if (cyc !== 0) $display("FAIL zero_latency: got %0d expected %0d", cyc, 0); else n_pass++;
      n_checks++; if (s !== 48'h0) $display("FAIL zero_sum: got %0d expected %0d", s, 0); else n_pass++;
      n_checks++; if (st !== 32'h1) $display("FAIL zero_status: got %h expected %h", st, 32'h1); else n_pass++;
      n_checks++; if (ma !== 0) $display("FAIL zero_addr: got %0d expected %0d", ma, 0); else n_pass++;
      do_ack();
   endtask

   task automatic test_overflow();
      int cyc;
      @(negedge clk); ps_control2 = {16'd4, 16'h0001};
      cyc = 0;
      @(negedge clk);
      while (pl_status2[0] !== 1'b1 && cyc < 100) begin
         @(negedge clk); cyc++;
      end
      n_checks++; if (cyc !== 5) $display("FAIL ovf_latency: got %0d expected %0d", cyc, 5); else n_pass++;
      n_checks++; if (sum2 !== 33'h1_FFFF_FFFC) $display("FAIL ovf_sum: got %h expected %h", sum2, 33'h1_FFFF_FFFC); else n_pass++;
      n_checks++; if (pl_status2 !== 32'h5) $display("FAIL ovf_status: got %h expected %h", pl_status2, 32'h5); else n_pass++;
      @(negedge clk); ps_control2 = 32'h2;
      @(negedge clk); ps_control2 = 32'h0;
      n_checks++; if (pl_status2 !== 32'h4) $display("FAIL ovf_sticky: got %h expected %h", pl_status2, 32'h4); else n_pass++;
      n_checks++; if (sum2 !== 33'h1_FFFF_FFFC) $display("FAIL ovf_sum_hold: got %h expected %h", sum2, 33'h1_FFFF_FFFC); else n_pass++;
   endtask

   task automatic test_reset_midrun();
      int cyc, be, ma; logic [47:0] s; logic [31:0] st;
      fill(32'd6, 1'b0);
      @(negedge clk); ps_control = {16'd1024, 16'h0001};
      repeat (501) @(negedge clk);
      n_checks++; if (pl_status !== 32'h2) $display("FAIL midrun_busy: got %h expected %h", pl_status, 32'h2); else n_pass++;
      #2 reset = 1'b0;
      #1;
      n_checks++; if (pl_status !== 32'h0) $display("FAIL midrun_status: got %h expected %h", pl_status, 32'h0); else n_pass++;
      n_checks++; if (sum_out !== 48'h0) $display("FAIL midrun_sum: got %h expected %h", sum_out, 48'h0); else n_pass++;
      n_checks++; if (addr !== 12'h0) $display("FAIL midrun_addr: got %h expected %h", addr, 12'h0); else n_pass++;
      @(negedge clk); reset = 1'b1;
      repeat (5) @(negedge clk);
      n_checks++; if (pl_status !== 32'h0) $display("FAIL held_start_norun: got %h expected %h", pl_status, 32'h0); else n_pass++;
      @(negedge clk); ps_control[0] = 1'b0;
      do_run(4, 1'b0, cyc, s, st, be, ma);
      n_checks++; if (s !== 48'd24) $display("FAIL post_reset_sum: got %0d expected %0d", s, 24); else n_pass++;
      n_checks++; if (cyc !== 5) $display("FAIL post_reset_latency: got %0d expected %0d", cyc, 5); else n_pass++;
      do_ack();
   endtask

   task automatic test_ack_start_interplay();
      int cyc, be, ma; logic [47:0] s; logic [31:0] st;
      fill(32'd6, 1'b0);
      do_run(2, 1'b1, cyc, s, st, be, ma);
      n_checks++; if (s !== 48'd12) $display("FAIL held_run_sum: got %0d expected %0d", s, 12); else n_pass++;
      @(negedge clk); ps_control = {16'd2, 16'h0003};
      @(negedge clk); ps_control = {16'd2, 16'h0001};
      repeat (4) @(negedge clk);
      n_checks++; if (pl_status !== 32'h0) $display("FAIL held_ack_idle: got %h expected %h", pl_status, 32'h0); else n_pass++;
      @(negedge clk); ps_control[0] = 1'b0;
      do_run(3, 1'b0, cyc, s, st, be, ma);
      n_checks++; if (s !== 48'd18) $display("FAIL combo_run_sum: got %0d expected %0d", s, 18); else n_pass++;
      @(negedge clk); ps_control = {16'd3, 16'h0003};
      @(negedge clk); ps_control = {16'd3, 16'h0001};
      repeat (4) @(negedge clk);
      n_checks++; if (pl_status !== 32'h0) $display("FAIL combo_idle: got %h expected %h", pl_status, 32'h0); else n_pass++;
      n_checks++; if (sum_out !== 48'd18) $display("FAIL combo_sum_hold: got %0d expected %0d", sum_out, 18); else n_pass++;
      n_checks++; if (addr !== 12'h0) $display("FAIL combo_addr: got %h expected %h", addr, 12'h0); else n_pass++;
      @(negedge clk); ps_control = '0;
   endtask

   task automatic test_write_port();
      n_checks++; if (side_bad !== 1'b0) $display("FAIL write_port_zero: got %b expected %b", side_bad, 1'b0); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_all_sixes();
      test_negative();
      test_ramp();
      test_clamp();
      test_zero();
      test_overflow();
      test_reset_midrun();
      test_ack_start_interplay();
      test_write_port();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/product_reduce.md
PRODUCT_REDUCE -- requirements
Module: product_reduce

Interface
REQ-001 SHALL have parameter BRAM_WIDTH, default 32, product BRAM word width in bits.
REQ-002 SHALL have parameter WORD_BYTES, default 4, byte-enable width and address stride.
REQ-003 SHALL have parameter ADDR_WIDTH, default 12, byte-address width of the product BRAM.
REQ-004 SHALL have parameter NUM_WORDS, default 1024, maximum words reduced per run.
REQ-005 SHALL have parameter ACC_WIDTH, default 48, signed accumulator width, at least BRAM_WIDTH+1.
REQ-006 SHALL have port clk, input, 1, sole clock; all state updates on posedge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port ps_control, input, 32, with bit0=start, bit1=ack, and [31:16]=word count N.
REQ-009 SHALL have port pl_status, output, 32, with bit0=done, bit1=busy, bit2=overflow, and the rest 0.
REQ-010 SHALL have port bram_addr_product, output, ADDR_WIDTH, product BRAM byte address.
REQ-011 SHALL have port bram_rddata_product, input, BRAM_WIDTH, product BRAM read data.
REQ-012 SHALL have port bram_wrdata_product, output, BRAM_WIDTH, tied to 0.
REQ-013 SHALL have port bram_we_product, output, WORD_BYTES, tied to 0 (read-only consumer).
REQ-014 SHALL have port sum_out, output, ACC_WIDTH, signed reduction result.

Function
REQ-015 SHALL implement the FSM states IDLE, READ, DRAIN and DONE.
REQ-016 SHALL detect start as a rising edge of ps_control[0], registered against the previous cycle's value; the edge SHALL be acted on only in IDLE, and a level held high SHALL NOT restart.
REQ-017 SHALL latch N at the start edge, clamped to NUM_WORDS.
REQ-018 SHALL, on a start edge at posedge t with N>0, go IDLE->READ; accumulator, overflow and word index SHALL clear and bram_addr_product SHALL be 0.
REQ-019 SHALL, in READ, drive bram_addr_product = index*WORD_BYTES and increment index each cycle; after issuing address (N-1)*WORD_BYTES it SHALL go to DRAIN.
REQ-020 SHALL treat BRAM read latency as 1 cycle: data for an address issued in cycle k is valid in cycle k+1 and SHALL be accumulated at the end of cycle k+1 via a 1-bit valid pipeline.
REQ-021 SHALL hold DRAIN for exactly one cycle while the last word is accumulated, then go to DONE.
REQ-022 SHALL enter DONE at posedge t+N+1; from that edge sum_out SHALL hold the final sum and done=1, busy=0.
REQ-023 SHALL, on a start edge with N=0, go IDLE->DONE at posedge t with sum_out=0.
REQ-024 SHALL sign-extend each word to ACC_WIDTH before adding.
REQ-025 SHALL set overflow (sticky until the next start) on signed overflow of any add; the accumulator SHALL wrap.
REQ-026 SHALL assert busy=1 in READ and DRAIN only.
REQ-027 SHALL, in DONE with ps_control[1]=1 at a posedge, go DONE->IDLE and clear done; sum_out and overflow SHALL hold until the next start.
REQ-028 SHALL ignore ack outside DONE.
REQ-029 SHALL, when start edge and ack occur in the same DONE cycle, give priority to ack; the start edge is consumed and SHALL NOT launch a run.
REQ-030 SHALL ignore a start edge in READ, DRAIN or DONE.
REQ-031 SHALL hold bram_addr_product at 0 in IDLE and DONE.

Reset
REQ-032 SHALL, while reset=0 at any time including mid-run, immediately force state=IDLE and set sum_out, pl_status, bram_addr_product, accumulator, index, valid pipe and previous start bit to 0.
REQ-033 SHALL require a fresh start rising edge after reset release before a new run begins.

Verification
REQ-034 SHALL be verified by: product words all 6, N=1024, start at t -> busy over t..t+1024, done at t+1025, sum_out=6144, overflow=0.
REQ-035 SHALL be verified by: words 0xFFFFFFFF (-1), N=16 -> sum_out=-16 in ACC_WIDTH two's complement, done at t+17.
REQ-036 SHALL be verified by: ACC_WIDTH=33, words 0x7FFFFFFF, N=4 -> overflow=1 at done, sum_out equal to the wrapped 33-bit value.
REQ-037 SHALL be verified by: N=0 -> done at posedge t, sum_out=0, no non-zero address driven.
REQ-038 SHALL be verified by: reset=0 after 500 words of an N=1024 run -> pl_status=0, sum_out=0 and addr=0 immediately; start held high after release -> no run; a new 0->1 start -> a correct run.
REQ-039 SHALL be verified by: ps_control[0] held 1 through ack -> stays IDLE; start and ack together in DONE -> IDLE with no new run; bram_we_product=0 throughout.
